// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing with a
// mem_ready handshake and a sticky halt trap. Define CTRL_PERF_CNT_EN for performance counters.
module multicycle_ctrl_fsm #(
  parameter int unsigned ALU_OP_W  = 4,
  parameter int unsigned TIMEOUT_W = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                mem_read,
  output logic                mem_write,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                is_shift,
  output logic                reg_dst,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                halted,
  output logic                illegal_instr,
  output logic                mem_timeout,
  output logic [CNT_W-1:0]    instr_retired,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam logic [5:0] OpR = 6'b000000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpBeq = 6'b000100, OpBne = 6'b000101, OpJ = 6'b000010;
  localparam logic [5:0] OpAddi = 6'b001000, OpAndi = 6'b001100, OpOri = 6'b001101;
  localparam logic [5:0] FnAdd = 6'b100000, FnSub = 6'b100010, FnAnd = 6'b100100;
  localparam logic [5:0] FnOr = 6'b100101, FnSll = 6'b000000, FnSrl = 6'b000010;
  localparam logic [5:0] FnSra = 6'b000011;
  localparam logic [3:0] AluAdd = 4'b0010, AluSub = 4'b1010, AluAnd = 4'b0100;
  localparam logic [3:0] AluOr = 4'b0101, AluSll = 4'b0110, AluSrl = 4'b0111;
  localparam logic [3:0] AluSra = 4'b1000;
  // Count value seen on the last permitted wait cycle (limit minus one).
  localparam logic [TIMEOUT_W-1:0] WaitLast = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StMemAddr, StMemRd, StMemWb, StMemWr,
    StRExec, StRWb, StIExec, StIWb, StBranch, StJump, StHalt
  } state_e;

  state_e                 state_q, state_d;
  logic [TIMEOUT_W-1:0]   wait_q;
  logic                   illegal_q, timeout_q;
  logic                   set_illegal, set_timeout;
  logic                   waiting, wait_limit, funct_legal;

  assign waiting     = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign wait_limit  = waiting && !mem_ready && (wait_q == WaitLast);
  assign funct_legal = (funct == FnAdd) || (funct == FnSub) || (funct == FnAnd) ||
                       (funct == FnOr) || (funct == FnSll) || (funct == FnSrl) ||
                       (funct == FnSra);

  always_comb begin
    state_d     = state_q;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    case (state_q)
      StIdle:    state_d = StFetch;
      StFetch: begin
        if (mem_ready)       state_d = StDecode;
        else if (wait_limit) begin state_d = StHalt; set_timeout = 1'b1; end
      end
      StDecode: begin
        case (opcode)
          OpLw, OpSw:             state_d = StMemAddr;
          OpR: begin
            if (funct_legal) state_d = StRExec;
            else begin state_d = StHalt; set_illegal = 1'b1; end
          end
          OpAddi, OpAndi, OpOri:  state_d = StIExec;
          OpBeq, OpBne:           state_d = StBranch;
          OpJ:                    state_d = StJump;
          default: begin state_d = StHalt; set_illegal = 1'b1; end
        endcase
      end
      StMemAddr: state_d = (opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd: begin
        if (mem_ready)       state_d = StMemWb;
        else if (wait_limit) begin state_d = StHalt; set_timeout = 1'b1; end
      end
      StMemWr: begin
        if (mem_ready)       state_d = StFetch;
        else if (wait_limit) begin state_d = StHalt; set_timeout = 1'b1; end
      end
      StRExec:   state_d = StRWb;
      StIExec:   state_d = StIWb;
      StMemWb, StRWb, StIWb, StBranch, StJump: state_d = StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_d != state_q) || mem_ready || !waiting) wait_q <= '0;
      else                                               wait_q <= wait_q + 1'b1;
      illegal_q <= illegal_q | set_illegal;
      timeout_q <= timeout_q | set_timeout;
    end
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = '0;
    is_shift   = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_OP_W'(AluAdd);
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_OP_W'(AluAdd);
      end
      StMemAddr, StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_OP_W'(AluAdd);
        if (state_q == StIExec) begin
          if (opcode == OpAndi)     alu_op = ALU_OP_W'(AluAnd);
          else if (opcode == OpOri) alu_op = ALU_OP_W'(AluOr);
        end
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        case (funct)
          FnSub:   alu_op = ALU_OP_W'(AluSub);
          FnAnd:   alu_op = ALU_OP_W'(AluAnd);
          FnOr:    alu_op = ALU_OP_W'(AluOr);
          FnSll:   begin alu_op = ALU_OP_W'(AluSll); is_shift = 1'b1; end
          FnSrl:   begin alu_op = ALU_OP_W'(AluSrl); is_shift = 1'b1; end
          FnSra:   begin alu_op = ALU_OP_W'(AluSra); is_shift = 1'b1; end
          default: alu_op = ALU_OP_W'(AluAdd);
        endcase
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StIWb:  reg_write = 1'b1;
      StBranch: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_W'(AluSub);
        pc_src    = 2'b01;
        pc_write  = (opcode == OpBne) ? ~zero : zero;
      end
      StJump: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign halted        = (state_q == StHalt);
  assign illegal_instr = illegal_q;
  assign mem_timeout   = timeout_q;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q, retired_q;
  logic             retire;

  // An instruction retires when control returns to FETCH from its final state.
  assign retire = (state_d == StFetch) &&
                  ((state_q == StMemWb) || (state_q == StMemWr) || (state_q == StRWb) ||
                   (state_q == StIWb) || (state_q == StBranch) || (state_q == StJump));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      if ((state_q != StIdle) && (state_q != StHalt)) cycle_q <= cycle_q + 1'b1;
      if (retire) retired_q <= retired_q + 1'b1;
    end
  end

  assign cycle_count   = cycle_q;
  assign instr_retired = retired_q;
`else
  assign cycle_count   = '0;
  assign instr_retired = '0;
`endif

endmodule
